// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key schedule: expands the cipher key forward to round 10, then serves round keys 10..0.
// Optional AES_KEY_CACHE_EN: keeps all 11 round keys in a register file and adds cache_idx/cache_key.
module aes_inv_key_sched #(
    parameter int KEY_W = 128,
    parameter int NR    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_load,
    input  logic             restart,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_round,
`ifdef AES_KEY_CACHE_EN
    input  logic [3:0]       cache_idx,
    output logic [KEY_W-1:0] cache_key,
`endif
    output logic             rk_last
);
    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_SERVE} state_t;
    localparam logic [3:0] LAST_RND = 4'(NR);

    if (KEY_W != 128 || NR != 10) begin : g_param_chk
        $error("aes_inv_key_sched supports only KEY_W=128 and NR=10");
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    state_t             r_state, w_state_nxt;
    logic [KEY_W-1:0]   r_work, r_rk_out, r_k10;
    logic [3:0]         r_cnt, r_rk_round;
    logic               r_k10_ok, r_rk_valid;
    logic               w_hs, w_restart_ok, w_exp_done;
    logic [KEY_W-1:0]   w_fwd, w_prev;

    assign w_hs         = r_rk_valid & rk_ready;
    assign w_restart_ok = restart & r_k10_ok & (r_state != S_EXPAND);
    assign w_exp_done   = (r_state == S_EXPAND) && (r_cnt == LAST_RND);
    assign w_fwd        = fwd_step(r_work, rcon(r_cnt));

`ifdef AES_KEY_CACHE_EN
    logic [KEY_W-1:0] r_rf [0:10];
    logic [KEY_W-1:0] r_cache_key;

    assign w_prev    = r_rf[r_rk_round - 4'd1];
    assign cache_key = r_cache_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= 10; i++) r_rf[i] <= '0;
            r_cache_key <= '0;
        end else begin
            if (key_load) r_rf[0] <= key_in;
            else if (r_state == S_EXPAND) r_rf[r_cnt] <= w_fwd;
            r_cache_key <= (cache_idx <= 4'd10) ? r_rf[cache_idx] : '0;
        end
    end
`else
    assign w_prev = inv_step(r_rk_out, rcon(r_rk_round));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (key_load) w_state_nxt = S_EXPAND;
        else begin
            case (r_state)
                S_IDLE:   if (w_restart_ok) w_state_nxt = S_SERVE;
                S_EXPAND: if (w_exp_done) w_state_nxt = S_SERVE;
                S_SERVE:  if (!w_restart_ok && w_hs && r_rk_round == 4'd0) w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // key_load beats restart, restart beats a handshake on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work     <= '0;
            r_rk_out   <= '0;
            r_k10      <= '0;
            r_cnt      <= '0;
            r_rk_round <= '0;
            r_k10_ok   <= 1'b0;
            r_rk_valid <= 1'b0;
        end else if (key_load) begin
            r_work     <= key_in;
            r_cnt      <= 4'd1;
            r_rk_valid <= 1'b0;
        end else if (w_restart_ok) begin
            r_rk_out   <= r_k10;
            r_rk_round <= LAST_RND;
            r_rk_valid <= 1'b1;
        end else if (r_state == S_EXPAND) begin
            r_work <= w_fwd;
            r_cnt  <= r_cnt + 4'd1;
            if (w_exp_done) begin
                r_rk_out   <= w_fwd;
                r_k10      <= w_fwd;
                r_k10_ok   <= 1'b1;
                r_rk_round <= LAST_RND;
                r_rk_valid <= 1'b1;
            end
        end else if (r_state == S_SERVE && w_hs) begin
            if (r_rk_round != 4'd0) begin
                r_rk_out   <= w_prev;
                r_rk_round <= r_rk_round - 4'd1;
            end else begin
                r_rk_valid <= 1'b0;
            end
        end
    end

    assign busy     = (r_state == S_EXPAND);
    assign rk_valid = r_rk_valid;
    assign rk_out   = r_rk_out;
    assign rk_round = r_rk_round;
    assign rk_last  = r_rk_valid & (r_rk_round == 4'd0);
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Randomized bench for aes_inv_key_sched against a FIPS-197 style word-expansion reference model.
module tb_aes_inv_key_sched;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] APP_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] APP_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_load = 1'b0, restart = 1'b0, rk_ready = 1'b0;
    logic         busy, rk_valid, rk_last;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
`ifdef AES_KEY_CACHE_EN
    logic [3:0]   cache_idx = '0;
    logic [127:0] cache_key;
`endif

    int n_checks = 0, n_fail = 0;
    logic [7:0]   sb [0:255];
    logic [127:0] exp_rk [0:10];

    aes_inv_key_sched dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load), .restart(restart),
        .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
        .rk_round(rk_round),
`ifdef AES_KEY_CACHE_EN
        .cache_idx(cache_idx), .cache_key(cache_key),
`endif
        .rk_last(rk_last)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // S-box table from the multiply-by-3 / divide-by-3 generator walk
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ ((q << 1) | (q >> 7)) ^ ((q << 2) | (q >> 6)) ^
                ((q << 3) | (q >> 5)) ^ ((q << 4) | (q >> 4));
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]] ^ rc, sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic load_key(input logic [127:0] k, input logic with_restart);
        int cnt;
        key_in = k;
        key_load = 1'b1;
        restart = with_restart;
        step();
        key_load = 1'b0;
        restart = 1'b0;
        build_model(k);
        chk("load_valid_drop", rk_valid, 0);
        chk("load_busy", busy, 1);
        cnt = 0;
        while (!rk_valid && cnt < 20) begin
            step();
            cnt++;
        end
        chk("latency", cnt, 10);
        chk("busy_done", busy, 0);
        chk("r10_round", rk_round, 10);
        chk("r10_key", rk_out, exp_rk[10]);
    endtask

    // Walks rounds 10..0 under random backpressure; r only moves on an observed handshake
    task automatic run_serve(input int pct, input logic [127:0] k);
        int r, cyc;
        logic rdy, hs;
        r = 10;
        cyc = 0;
        while (r >= 0 && cyc < 400) begin
            chk("srv_valid", rk_valid, 1);
            chk("srv_round", rk_round, r);
            chk("srv_key", rk_out, exp_rk[r]);
            chk("srv_last", rk_last, (r == 0));
            if (k == FIPS_KEY && r == 1) chk("kat_r1", rk_out, FIPS_R1);
            rdy = ($urandom_range(99) < pct);
            rk_ready = rdy;
            hs = rk_valid & rdy;
            step();
            cyc++;
            if (hs) r--;
        end
        rk_ready = 1'b0;
        chk("serve_done", (r < 0), 1);
        chk("end_valid", rk_valid, 0);
        chk("end_last", rk_last, 0);
        chk("end_key_is_cipher", rk_out, k);
    endtask

    initial begin
        logic [127:0] k;
        build_sbox();
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_valid", rk_valid, 0);
        chk("rst_out", rk_out, 0);
        chk("rst_round", rk_round, 0);
        chk("rst_last", rk_last, 0);
        #10 rst_n = 1'b1;
        step();

        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_noload", rk_valid, 0);
        step();
        chk("restart_noload2", rk_valid, 0);

        rk_ready = 1'b1;
        load_key(FIPS_KEY, 1'b0);
        chk("fips_r10", rk_out, FIPS_R10);
        run_serve(100, FIPS_KEY);

`ifdef AES_KEY_CACHE_EN
        cache_idx = 4'd1;
        step();
        chk("cache_r1", cache_key, FIPS_R1);
        cache_idx = 4'd12;
        step();
        chk("cache_oob", cache_key, 0);
`endif

        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_valid", rk_valid, 1);
        chk("restart_round", rk_round, 10);
        chk("restart_key", rk_out, FIPS_R10);
        chk("restart_busy", busy, 0);
        run_serve(50, FIPS_KEY);

        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            load_key(k, 1'b0);
            run_serve($urandom_range(90, 20), k);
        end

        k = {$urandom, $urandom, $urandom, $urandom};
        load_key(k, 1'b1);
        run_serve(60, k);

        k = {$urandom, $urandom, $urandom, $urandom};
        load_key(k, 1'b0);
        rk_ready = 1'b1;
        for (int r = 10; r > 6; r--) step();
        chk("pre_reload_round", rk_round, 6);
        load_key(APP_KEY, 1'b0);
        chk("app_r10", rk_out, APP_R10);
        run_serve(100, APP_KEY);

        k = {$urandom, $urandom, $urandom, $urandom};
        load_key(k, 1'b0);
        rk_ready = 1'b1;
        step();
        step();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", rk_valid, 0);
        chk("arst_out", rk_out, 0);
        chk("arst_round", rk_round, 0);
        chk("arst_last", rk_last, 0);
        repeat (3) step();
        chk("arst_hold_valid", rk_valid, 0);
        rst_n = 1'b1;
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_after_rst", rk_valid, 0);
        rk_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Sequential AES-128 key schedule for the decryption datapath.
- Expands a loaded cipher key forward to the round-10 key, then serves round keys in reverse order (10 down to 0), one per valid/ready handshake.
- Feeds the AddRoundKey stage immediately upstream of the inverse column-mixing stage; one full key is produced per decrypt round.
- Byte/word ordering matches the datapath: bits [127:120] are state byte 0; word 0 (first column) is [127:96].

Parameters:
- KEY_W, 128, key/round-key width; only 128 is legal.
- NR, 10, number of rounds; only 10 is legal, checked by elaboration assertion.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  128  cipher key, sampled when key_load=1.
- key_load  input  1  single-cycle pulse; starts a new expansion.
- restart  input  1  single-cycle pulse; re-serve from round 10 using the cached round-10 key.
- busy  output  1  high while expanding.
- rk_valid  output  1  rk_out holds a valid round key.
- rk_ready  input  1  consumer accepts rk_out.
- rk_out  output  128  current round key.
- rk_round  output  4  round index of rk_out (10..0).
- rk_last  output  1  high when rk_valid=1 and rk_round=0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, rk_valid=0, rk_out=0, rk_round=0, rk_last=0, k10 cache=0, k10_ok=0.
- States: IDLE, EXPAND, SERVE.
- key_load (any state, including mid-EXPAND or mid-SERVE):
  - Latch key_in into the working register; cnt=1; state=EXPAND; rk_valid=0 next cycle.
  - Any in-flight key is discarded.
- EXPAND: one forward round per clock, using Rcon[cnt].
  - Forward step: w0' = w0^SubWord(RotWord(w3))^{Rcon,24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - After 10 edges: write the round-10 key to the working register and to the k10 cache; set k10_ok=1; rk_round=10; rk_valid=1; state=SERVE.
  - Latency: rk_valid rises exactly 10 clock edges after the edge that sampled key_load.
- SERVE: rk_out, rk_round and rk_valid are registered and hold stable while rk_valid=1 and rk_ready=0.
- Handshake = rk_valid & rk_ready:
  - If rk_round>0: next rk_out = inverse step with Rcon[rk_round]; rk_round decrements. rk_valid stays 1, giving back-to-back throughput of one key per cycle.
  - Inverse step: p3 = k3^k2; p2 = k2^k1; p1 = k1^k0; p0 = k0^SubWord(RotWord(p3))^{Rcon,24'h0}.
  - If rk_round=0: rk_valid=0; state=IDLE; rk_out holds the round-0 key, which equals the cipher key.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, from a case table on the index.
- SubWord uses a FIPS-197 S-box function inside the block; no external S-box.
- restart:
  - In IDLE or SERVE with k10_ok=1: next cycle rk_out=k10 cache, rk_round=10, rk_valid=1, state=SERVE.
  - With k10_ok=0, or during EXPAND: ignored.
- Simultaneous events:
  - key_load and restart in the same cycle: key_load wins.
  - key_load and a handshake in the same cycle: the handshake is consumed; the new expansion starts and no further keys of the old schedule are produced.
- rk_last is combinational: rk_valid & (rk_round==0).
- busy=1 exactly in EXPAND.

Optional Feature:
- Macro: AES_KEY_CACHE_EN.
- Defined:
  - During EXPAND, all 11 round keys (round 0 = cipher key) are stored in an 11x128 register file.
  - SERVE reads the register file at rk_round instead of computing the inverse step.
  - Adds ports cache_idx (input, 4 bits) and cache_key (output, 128 bits). cache_key is registered, with 1-cycle read latency.
  - cache_key is valid when k10_ok=1; an index above 10 reads 0.
- Undefined: on-the-fly inverse step only; no extra ports or storage.
- rk_* port timing is identical with and without the macro.

Test Plan:
- Reset check: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; hold rk_ready=1 -> no rk_valid.
- FIPS-197 vector: key_in=2b7e151628aed2a6abf7158809cf4f3c, pulse key_load, rk_ready=1 -> rk_valid rises 10 edges later with rk_round=10 and rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6. Then 10 consecutive keys follow, including round 1 = a0fafe1788542cb123a339392a6c7605 and round 0 = the cipher key with rk_last=1; rk_valid drops the next cycle.
- Backpressure: rk_ready toggles randomly -> rk_out/rk_round stable while stalled; sequence 10..0 is unchanged and no key is skipped or duplicated.
- Restart: after the full sequence, pulse restart -> rk_valid the next cycle with round 10 = d014f9a8...; busy stays 0.
- Mid-operation reload: key_load with key=000102030405060708090a0b0c0d0e0f while in SERVE at round 6 -> rk_valid drops; 10 edges later rk_out=13111d7fe3944a17f307a78b4d2b30c5 with rk_round=10.
- Simultaneous key_load+restart, and restart before any load -> key_load wins; restart with k10_ok=0 produces no rk_valid.
